// File: rtl/iomem_pkg.sv
// iomem_pkg
// Shared types and constants for the iomem responder slice.
//   IOMEM_ADDR_W / IOMEM_DATA_W / IOMEM_STRB_W : bus field widths
//   iomem_resp_state_t                         : responder FSM states
//   IOMEM_LFSR_SEED, iomem_lfsr_next()         : delay-stress LFSR (x^8+x^6+x^5+x^4+1)
package iomem_pkg;

  localparam int IOMEM_ADDR_W = 32;
  localparam int IOMEM_DATA_W = 32;
  localparam int IOMEM_STRB_W = 4;

  localparam logic [7:0] IOMEM_LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } iomem_resp_state_t;

  // Fibonacci form, taps at bits 8,6,5,4 (1-based).
  function automatic logic [7:0] iomem_lfsr_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/iomem_byte_ram.sv
// iomem_byte_ram
// DEPTH x 32-bit single-port RAM with per-byte write enables and a
// registered read. The read register only updates when re_i is high, so
// the last read word is held between accesses.
// Ports:
//   clk_i    in   1        clock
//   addr_i   in   AW       word index shared by read and write
//   we_i     in   4        byte-lane write enables (lane n = bits [8n+7:8n])
//   wdata_i  in   32       write data
//   re_i     in   1        load read register from mem[addr_i]
//   rdata_o  out  32       registered read data
module iomem_byte_ram
  import iomem_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter int AW        = 12,
  parameter     INIT_FILE = ""
) (
  input  logic                    clk_i,
  input  logic [AW-1:0]           addr_i,
  input  logic [IOMEM_STRB_W-1:0] we_i,
  input  logic [IOMEM_DATA_W-1:0] wdata_i,
  input  logic                    re_i,
  output logic [IOMEM_DATA_W-1:0] rdata_o
);

  logic [IOMEM_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int n = 0; n < IOMEM_STRB_W; n++) begin
      if (we_i[n]) begin
        mem[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
      end
    end
    if (re_i) begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/iomem_responder.sv
// iomem_responder
// Target for the islemci iomem bus: word-addressed, byte-writable RAM with
// a programmable response latency and an out-of-range error strobe.
// Ports:
//   clk_i          in   1    clock, rising edge
//   rst_i          in   1    synchronous active-high reset
//   iomem_valid_i  in   1    request valid, held until ready
//   iomem_ready_o  out  1    single-cycle response strobe
//   iomem_wstrb_i  in   4    byte write enables, 0 = read
//   iomem_addr_i   in   32   byte address, [1:0] ignored
//   iomem_wdata_i  in   32   write data
//   iomem_rdata_o  out  32   read data, valid with ready
//   err_o          out  1    out-of-range access, pulses with ready
// Optional feature macro: IOMEM_RESP_RANDOM_DELAY_EN adds 0..3 extra wait
// cycles per request from an 8-bit LFSR.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request in flight; request fields latched on valid
// WAIT  | counting down latency; valid low here aborts the request
// RESP  | ready (and err if out of range) high; write commits at edge
module iomem_responder
  import iomem_pkg::*;
#(
  parameter logic [IOMEM_ADDR_W-1:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [IOMEM_ADDR_W-1:0] MEM_DEPTH = 32'h0000_1000,
  parameter int                      LATENCY   = 1,
  parameter                          INIT_FILE = ""
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    iomem_valid_i,
  output logic                    iomem_ready_o,
  input  logic [IOMEM_STRB_W-1:0] iomem_wstrb_i,
  input  logic [IOMEM_ADDR_W-1:0] iomem_addr_i,
  input  logic [IOMEM_DATA_W-1:0] iomem_wdata_i,
  output logic [IOMEM_DATA_W-1:0] iomem_rdata_o,
  output logic                    err_o
);

  localparam int AW    = $clog2(MEM_DEPTH);
  // Wide enough for LATENCY (<=15) plus up to 3 random extra cycles.
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

  iomem_resp_state_t state_q, state_d;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        lat_total;
  logic [AW-1:0]           idx_q, idx_sel;
  logic [IOMEM_STRB_W-1:0] wstrb_q;
  logic [IOMEM_DATA_W-1:0] wdata_q;
  logic                    in_range_q, in_range_in, in_range_sel;
  logic                    zero_q;
  logic                    accept, rd_en;
  logic [IOMEM_ADDR_W-1:0] offset_in;
  logic [IOMEM_DATA_W-1:0] ram_rdata;
  logic [IOMEM_STRB_W-1:0] ram_we;

  // Range check on the live address; addresses below BASE_ADDR wrap to a
  // huge offset, but the explicit >= keeps the intent obvious.
  assign offset_in   = iomem_addr_i - BASE_ADDR;
  assign in_range_in = (iomem_addr_i >= BASE_ADDR) && ((offset_in >> 2) < MEM_DEPTH);

  // With LATENCY=1 the RAM read happens on the accepting edge, before the
  // latched copy exists, so IDLE uses the live index.
  assign idx_sel      = (state_q == IDLE) ? offset_in[AW+1:2] : idx_q;
  assign in_range_sel = (state_q == IDLE) ? in_range_in : in_range_q;

`ifdef IOMEM_RESP_RANDOM_DELAY_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= IOMEM_LFSR_SEED;
    end else if (accept) begin
      lfsr_q <= iomem_lfsr_next(lfsr_q);
    end
  end

  assign lat_total = LAT + {3'b000, lfsr_q[1:0]};
`else
  assign lat_total = LAT;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (iomem_valid_i) begin
          accept = 1'b1;
          if (lat_total == CNT_W'(1)) begin
            state_d = RESP;
            rd_en   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = lat_total - CNT_W'(2);
          end
        end
      end
      WAIT: begin
        if (!iomem_valid_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      in_range_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q      <= idx_sel;
        in_range_q <= in_range_in;
        wstrb_q    <= iomem_wstrb_i;
        wdata_q    <= iomem_wdata_i;
      end
      // Forces rdata to zero for out-of-range responses (and after reset)
      // while letting the RAM read register hold the last good word.
      if (rd_en) begin
        zero_q <= ~in_range_sel;
      end
    end
  end

  // Write lands on the edge that closes RESP, so the RESP read sees the
  // pre-write word. A reset in that cycle cancels the write.
  assign ram_we = (state_q == RESP && in_range_q && !rst_i) ? wstrb_q : '0;

  iomem_byte_ram #(
    .DEPTH     (int'(MEM_DEPTH)),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk_i   (clk_i),
    .addr_i  (idx_sel),
    .we_i    (ram_we),
    .wdata_i (wdata_q),
    .re_i    (rd_en & ~rst_i),
    .rdata_o (ram_rdata)
  );

  assign iomem_ready_o = (state_q == RESP);
  assign err_o         = (state_q == RESP) && !in_range_q;
  assign iomem_rdata_o = zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_iomem_responder.sv
// tb_iomem_responder
// Directed bench for iomem_responder: one instance with LATENCY=1 and one
// with LATENCY=4. A vector table covers read/write/strobe/range cases,
// followed by abort, reset-during-wait, back-to-back and a random
// scoreboard section. Honors IOMEM_RESP_RANDOM_DELAY_EN for latency bounds.
module tb_iomem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        valid [2];
  logic [3:0]  wstrb [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];

  iomem_responder #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst[0]), .iomem_valid_i(valid[0]), .iomem_ready_o(ready[0]),
    .iomem_wstrb_i(wstrb[0]), .iomem_addr_i(addr[0]), .iomem_wdata_i(wdata[0]),
    .iomem_rdata_o(rdata[0]), .err_o(err[0])
  );

  iomem_responder #(.LATENCY(4)) dut4 (
    .clk_i(clk), .rst_i(rst[1]), .iomem_valid_i(valid[1]), .iomem_ready_o(ready[1]),
    .iomem_wstrb_i(wstrb[1]), .iomem_addr_i(addr[1]), .iomem_wdata_i(wdata[1]),
    .iomem_rdata_o(rdata[1]), .err_o(err[1])
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          sel;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    bit          chk_rd;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] model [16];

  function automatic vec_t mk(input int sel, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d, input logic [31:0] r, input logic e,
                              input int lat, input bit c);
    vec_t v;
    v.sel = sel; v.addr = a; v.strb = s; v.wdata = d;
    v.rdata = r; v.err = e; v.lat = lat; v.chk_rd = c;
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_lat(input string name, input int act, input int exp);
    checks++;
`ifdef IOMEM_RESP_RANDOM_DELAY_EN
    if (act < exp || act > exp + 3) begin
      errors++;
      $display("FAIL %s: latency %0d expected %0d..%0d", name, act, exp, exp + 3);
    end
`else
    if (act != exp) begin
      errors++;
      $display("FAIL %s: latency %0d expected %0d", name, act, exp);
    end
`endif
  endtask

  // Drives one request in an IDLE cycle and waits (bounded) for ready.
  // lat = number of rising edges from the first sampling edge to ready;
  // lat = 0 means no ready within the budget.
  task automatic xfer(input int sel, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] rd, output logic e,
                      output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    rd  = '0;
    e   = 1'b0;
    @(negedge clk);
    valid[sel] = 1'b1;
    addr[sel]  = a;
    wstrb[sel] = s;
    wdata[sel] = d;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ready[sel]) begin
        got = 1'b1;
        lat = i;
        rd  = rdata[sel];
        e   = err[sel];
      end
    end
    valid[sel] = 1'b0;
    wstrb[sel] = 4'h0;
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          seen;
    int          pulses;
    int          dbl;
    logic        prev;
    int          k;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] a;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; valid[i] = 1'b0; wstrb[i] = 4'h0; addr[i] = '0; wdata[i] = '0;
    end

    vecs[0]  = mk(0, 32'h4000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0, 1, 1'b0);
    vecs[1]  = mk(0, 32'h4000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0, 1, 1'b1);
    vecs[2]  = mk(0, 32'h4000_0010, 4'hF, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0, 1, 1'b1);
    vecs[3]  = mk(0, 32'h4000_0010, 4'h5, 32'hAABB_CCDD, 32'h1122_3344, 1'b0, 1, 1'b1);
    vecs[4]  = mk(0, 32'h4000_0010, 4'h0, 32'h0,         32'h11BB_33DD, 1'b0, 1, 1'b1);
    vecs[5]  = mk(0, 32'h4000_0000, 4'hF, 32'h0000_AAAA, 32'h0,         1'b0, 1, 1'b0);
    vecs[6]  = mk(0, 32'h4000_3FFC, 4'hF, 32'h5555_0FFF, 32'h0,         1'b0, 1, 1'b0);
    vecs[7]  = mk(0, 32'h4000_3FFC, 4'h0, 32'h0,         32'h5555_0FFF, 1'b0, 1, 1'b1);
    vecs[8]  = mk(0, 32'h3FFF_FFFC, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1, 1, 1'b1);
    vecs[9]  = mk(0, 32'h4000_4000, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1, 1, 1'b1);
    vecs[10] = mk(0, 32'h4000_0000, 4'h0, 32'h0,         32'h0000_AAAA, 1'b0, 1, 1'b1);
    vecs[11] = mk(0, 32'h4000_3FFC, 4'h0, 32'h0,         32'h5555_0FFF, 1'b0, 1, 1'b1);
    vecs[12] = mk(0, 32'h4000_0013, 4'h0, 32'h0,         32'h11BB_33DD, 1'b0, 1, 1'b1);
    vecs[13] = mk(0, 32'h0000_0000, 4'h0, 32'h0,         32'h0,         1'b1, 1, 1'b1);
    vecs[14] = mk(1, 32'h4000_0020, 4'hF, 32'hCAFE_F00D, 32'h0,         1'b0, 4, 1'b0);
    vecs[15] = mk(1, 32'h4000_0020, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0, 4, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_ready%0d", i), {31'b0, ready[i]}, 32'h0);
      chk($sformatf("reset_err%0d", i),   {31'b0, err[i]},   32'h0);
      chk($sformatf("reset_rdata%0d", i), rdata[i],          32'h0);
    end

    for (int i = 0; i < 16; i++) begin
      xfer(vecs[i].sel, vecs[i].addr, vecs[i].strb, vecs[i].wdata, rd, e, lat);
      chk_lat($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, vecs[i].err});
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
    end

    // Read aborted in WAIT: no ready may appear.
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = 32'h4000_0020; wstrb[1] = 4'h0;
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (ready[1]) seen++; end
    valid[1] = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (ready[1]) seen++; end
    chk("abort_read_no_ready", seen, 0);

    // Write aborted in WAIT: no ready, and the word must be untouched.
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = 32'h4000_0020; wstrb[1] = 4'hF; wdata[1] = 32'h0;
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (ready[1]) seen++; end
    valid[1] = 1'b0; wstrb[1] = 4'h0;
    repeat (6) begin @(posedge clk); #1; if (ready[1]) seen++; end
    chk("abort_write_no_ready", seen, 0);
    xfer(1, 32'h4000_0020, 4'h0, 32'h0, rd, e, lat);
    chk("after_abort_rdata", rd, 32'hCAFE_F00D);
    chk_lat("after_abort_lat", lat, 4);

    // Reset while a write waits: no ready, no commit.
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = 32'h4000_0020; wstrb[1] = 4'hF; wdata[1] = 32'h1234_5678;
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (ready[1]) seen++; end
    rst[1] = 1'b1;
    @(posedge clk); #1;
    if (ready[1]) seen++;
    rst[1] = 1'b0; valid[1] = 1'b0; wstrb[1] = 4'h0;
    repeat (6) begin @(posedge clk); #1; if (ready[1]) seen++; end
    chk("rst_wait_no_ready", seen, 0);
    xfer(1, 32'h4000_0020, 4'h0, 32'h0, rd, e, lat);
    chk("rst_wait_word_kept", rd, 32'hCAFE_F00D);
    chk_lat("rst_wait_next_lat", lat, 4);
    chk("rst_wait_next_err", {31'b0, e}, 32'h0);

    // Back-to-back reads with valid held high.
    @(negedge clk);
    valid[0] = 1'b1; addr[0] = 32'h4000_0010; wstrb[0] = 4'h0;
    pulses = 0; dbl = 0; prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ready[0]) begin
        pulses++;
        if (prev) dbl++;
      end
      prev = ready[0];
    end
    valid[0] = 1'b0;
    @(posedge clk);
    chk("b2b_single_cycle_ready", dbl, 0);
`ifndef IOMEM_RESP_RANDOM_DELAY_EN
    chk("b2b_pulse_count", pulses, 4);
`endif

    // Random write/read pairs against a 16-word scoreboard.
    for (int w = 0; w < 16; w++) begin
      model[w] = $urandom;
      xfer(0, 32'h4000_0000 + 32'(w * 4), 4'hF, model[w], rd, e, lat);
      chk_lat($sformatf("fill%0d_lat", w), lat, 1);
    end
    for (int p = 0; p < 40; p++) begin
      k = $urandom_range(0, 15);
      s = 4'($urandom_range(1, 15));
      d = $urandom;
      a = 32'h4000_0000 + 32'(k * 4);
      xfer(0, a, s, d, rd, e, lat);
      chk($sformatf("rnd%0d_wr_pre", p), rd, model[k]);
      chk_lat($sformatf("rnd%0d_wr_lat", p), lat, 1);
      model[k] = merge(model[k], d, s);
      xfer(0, a, 4'h0, 32'h0, rd, e, lat);
      chk($sformatf("rnd%0d_rd", p), rd, model[k]);
      chk_lat($sformatf("rnd%0d_rd_lat", p), lat, 1);
      chk($sformatf("rnd%0d_rd_err", p), {31'b0, e}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
